// File: rtl/sequenciador_multiciclo_pkg.sv
// Shared encodings for the multicycle sequencer: states, opcodes and ULA operations.
// Opcode field position within the instruction byte lives here too.
package sequenciador_multiciclo_pkg;

    typedef enum logic [2:0] {
        ST_INICIO     = 3'b000,
        ST_BUSCA      = 3'b001,
        ST_DECODIFICA = 3'b010,
        ST_EXECUTA    = 3'b011,
        ST_MEMORIA    = 3'b100,
        ST_ESCRITA    = 3'b101,
        ST_PARADO     = 3'b110,
        ST_ERRO       = 3'b111
    } estado_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_ADDI = 3'b010,
        OP_LW   = 3'b011,
        OP_SW   = 3'b100,
        OP_BEQ  = 3'b101,
        OP_J    = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_SUB   = 2'b01;
    localparam logic [1:0] ULA_PASSB = 2'b10;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 5;

    function automatic opcode_t extrai_opcode(input logic [7:0] instr);
        return opcode_t'(instr[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/sequenciador_watchdog.sv
// Memory-wait watchdog: counts stalled cycles, flags expiry on the last allowed cycle.
// Expiry is combinational so the FSM can leave for ERRO on the same edge.
module sequenciador_watchdog #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic limpa,
    input  logic habilita,
    output logic expirado
);

    logic [CW-1:0] contagem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            contagem <= '0;
        else if (limpa)
            contagem <= '0;
        else if (habilita)
            contagem <= contagem + 1'b1;
    end

    assign expirado = habilita && (contagem == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback with memory handshake,
// wait watchdog and completed-instruction counter. Strobes decode from state and opcode.
module sequenciador_multiciclo
    import sequenciador_multiciclo_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instru,
    input  logic       mem_pronto,
    input  logic       zero,
    output logic       irCarrega,
    output logic       escrita,
    output logic       escritaPC,
    output logic       ulaFonte,
    output logic [1:0] ulaOP,
    output logic       pula,
    output logic       regFonte,
    output logic       comparador,
    output logic       lerMemo,
    output logic       escreveMemo,
    output logic       parado,
    output logic       erro,
    output logic [2:0] estado,
    output logic [7:0] instr_contador
);

    estado_t st, st_prox;
    opcode_t op;
    logic    conclui;
    logic    expirado;
    logic    espera;
    logic    wd_limpa;
    logic [1:0] ula_exec;
    logic       fonte_exec;

    assign espera   = ((st == ST_BUSCA) || (st == ST_MEMORIA)) && !mem_pronto;
    assign wd_limpa = (st_prox != st) || mem_pronto;

    sequenciador_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .limpa    (wd_limpa),
        .habilita (espera),
        .expirado (expirado)
    );

    // conclui marks the edge that leaves an instruction's final state
    always_comb begin
        st_prox = st;
        conclui = 1'b0;
        case (st)
            ST_INICIO:     st_prox = ST_BUSCA;
            ST_BUSCA: begin
                if (mem_pronto)    st_prox = ST_DECODIFICA;
                else if (expirado) st_prox = ST_ERRO;
            end
            ST_DECODIFICA: st_prox = (op == OP_HALT) ? ST_PARADO : ST_EXECUTA;
            ST_EXECUTA: begin
                case (op)
                    OP_ADD, OP_SUB, OP_ADDI: st_prox = ST_ESCRITA;
                    OP_LW, OP_SW:            st_prox = ST_MEMORIA;
                    default: begin
                        st_prox = ST_BUSCA;
                        conclui = 1'b1;
                    end
                endcase
            end
            ST_MEMORIA: begin
                if (mem_pronto) begin
                    if (op == OP_LW) begin
                        st_prox = ST_ESCRITA;
                    end else begin
                        st_prox = ST_BUSCA;
                        conclui = 1'b1;
                    end
                end else if (expirado) begin
                    st_prox = ST_ERRO;
                end
            end
            ST_ESCRITA: begin
                st_prox = ST_BUSCA;
                conclui = 1'b1;
            end
            default: st_prox = st;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st             <= ST_INICIO;
            op             <= OP_ADD;
            instr_contador <= '0;
        end else begin
            st <= st_prox;
            if (irCarrega)
                op <= extrai_opcode(instru);
            if (conclui)
                instr_contador <= instr_contador + 8'd1;
        end
    end

    assign ula_exec   = ((op == OP_SUB) || (op == OP_BEQ)) ? ULA_SUB : ULA_ADD;
    assign fonte_exec = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    assign estado     = st;

    // Decoded from the state register so reset clears every strobe without a clock
    always_comb begin
        irCarrega   = 1'b0;
        escrita     = 1'b0;
        escritaPC   = 1'b0;
        ulaFonte    = 1'b0;
        ulaOP       = ULA_ADD;
        pula        = 1'b0;
        regFonte    = 1'b0;
        comparador  = 1'b0;
        lerMemo     = 1'b0;
        escreveMemo = 1'b0;
        parado      = 1'b0;
        erro        = 1'b0;
        case (st)
            ST_BUSCA: begin
                lerMemo = 1'b1;
                if (mem_pronto) begin
                    irCarrega = 1'b1;
                    escritaPC = 1'b1;
                end
            end
            ST_EXECUTA: begin
                ulaOP    = ula_exec;
                ulaFonte = fonte_exec;
                if (op == OP_BEQ) begin
                    comparador = 1'b1;
                    pula       = zero;
                    escritaPC  = zero;
                end else if (op == OP_J) begin
                    pula      = 1'b1;
                    escritaPC = 1'b1;
                end
            end
            ST_MEMORIA: begin
                ulaOP       = ula_exec;
                ulaFonte    = fonte_exec;
                lerMemo     = (op == OP_LW);
                escreveMemo = (op == OP_SW);
            end
            ST_ESCRITA: begin
                ulaOP    = ula_exec;
                ulaFonte = fonte_exec;
                escrita  = 1'b1;
                regFonte = (op == OP_LW);
            end
            ST_PARADO: parado = 1'b1;
            ST_ERRO:   erro   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Bench for sequenciador_multiciclo: per-instruction cycle sequences queued as expectations,
// a negedge monitor pops and compares the full output vector every cycle.
module tb_sequenciador_multiciclo;

    localparam logic [2:0] I_ADD = 3'd0, I_SUB = 3'd1, I_ADDI = 3'd2, I_LW = 3'd3,
                           I_SW = 3'd4, I_BEQ = 3'd5, I_J = 3'd6, I_HALT = 3'd7;

    typedef struct packed {
        logic [2:0] estado;
        logic       irCarrega;
        logic       escrita;
        logic       escritaPC;
        logic       ulaFonte;
        logic [1:0] ulaOP;
        logic       pula;
        logic       regFonte;
        logic       comparador;
        logic       lerMemo;
        logic       escreveMemo;
        logic       parado;
        logic       erro;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] instru = '0;
    logic       mem_pronto = 1'b0;
    logic       zero = 1'b0;
    logic       irCarrega, escrita, escritaPC, ulaFonte, pula, regFonte;
    logic       comparador, lerMemo, escreveMemo, parado, erro;
    logic [1:0] ulaOP;
    logic [2:0] estado;
    logic [7:0] instr_contador;

    int   checks = 0;
    int   passed = 0;
    int   ciclo  = 0;
    logic [7:0] cnt = '0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    sequenciador_multiciclo #(.TIMEOUT(15), .CW(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .instru         (instru),
        .mem_pronto     (mem_pronto),
        .zero           (zero),
        .irCarrega      (irCarrega),
        .escrita        (escrita),
        .escritaPC      (escritaPC),
        .ulaFonte       (ulaFonte),
        .ulaOP          (ulaOP),
        .pula           (pula),
        .regFonte       (regFonte),
        .comparador     (comparador),
        .lerMemo        (lerMemo),
        .escreveMemo    (escreveMemo),
        .parado         (parado),
        .erro           (erro),
        .estado         (estado),
        .instr_contador (instr_contador)
    );

    function automatic obs_t actual();
        obs_t a;
        a = '{estado, irCarrega, escrita, escritaPC, ulaFonte, ulaOP, pula, regFonte,
              comparador, lerMemo, escreveMemo, parado, erro, instr_contador};
        return a;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.estado = st;
        e.cnt    = cnt;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    // Monitor: every cycle with a queued expectation is compared at the falling edge
    always @(negedge clk) begin
        ciclo++;
        if (exp_q.size() > 0) begin
            obs_t ex, ac;
            ex = exp_q.pop_front();
            ac = actual();
            checks++;
            if (ac === ex) passed++;
            else $display("FAIL outputs cycle=%0d est=%0d got=%h want=%h", ciclo, ex.estado, ac, ex);
        end
    end

    task automatic step(input obs_t e, input logic mp, input logic z, input logic [7:0] ins);
        @(posedge clk);
        #1;
        mem_pronto = mp;
        zero       = z;
        instru     = ins;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cnt   = '0;
        mem_pronto = rb();
        exp_q.push_back(base(3'd0));
        @(posedge clk);
        #1;
        exp_q.push_back(base(3'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(base(3'd0));
    endtask

    // Fetch with bw stalled cycles; returns once the instruction word is accepted
    task automatic fetch(input logic [2:0] op, input int bw);
        obs_t e;
        for (int i = 0; i < bw; i++) begin
            e = base(3'd1); e.lerMemo = 1'b1;
            step(e, 1'b0, rb(), r8());
        end
        e = base(3'd1); e.lerMemo = 1'b1; e.irCarrega = 1'b1; e.escritaPC = 1'b1;
        step(e, 1'b1, rb(), {op, 5'($urandom)});
        e = base(3'd2);
        step(e, rb(), rb(), r8());
    endtask

    task automatic run_instr(input logic [2:0] op, input int bw, input int mw, input logic z);
        obs_t e;
        logic [1:0] ula;
        logic fonte, mem_op, wb_op;
        fetch(op, bw);
        if (op == I_HALT) begin
            repeat (3) begin
                e = base(3'd6); e.parado = 1'b1;
                step(e, rb(), rb(), r8());
            end
            return;
        end
        ula    = (op == I_SUB || op == I_BEQ) ? 2'b01 : 2'b00;
        fonte  = (op == I_ADDI || op == I_LW || op == I_SW);
        mem_op = (op == I_LW || op == I_SW);
        wb_op  = (op == I_ADD || op == I_SUB || op == I_ADDI || op == I_LW);
        e = base(3'd3); e.ulaOP = ula; e.ulaFonte = fonte;
        e.comparador = (op == I_BEQ);
        e.pula       = (op == I_J) || (op == I_BEQ && z);
        e.escritaPC  = e.pula;
        step(e, rb(), (op == I_BEQ) ? z : rb(), r8());
        if (mem_op) begin
            for (int i = 0; i <= mw; i++) begin
                e = base(3'd4); e.ulaOP = ula; e.ulaFonte = fonte;
                e.lerMemo = (op == I_LW); e.escreveMemo = (op == I_SW);
                step(e, (i == mw), rb(), r8());
            end
        end
        if (wb_op) begin
            e = base(3'd5); e.ulaOP = ula; e.ulaFonte = fonte;
            e.escrita = 1'b1; e.regFonte = (op == I_LW);
            step(e, rb(), rb(), r8());
        end
        cnt = cnt + 8'd1;
    endtask

    task automatic run_timeout();
        obs_t e;
        for (int i = 0; i < 15; i++) begin
            e = base(3'd1); e.lerMemo = 1'b1;
            step(e, 1'b0, rb(), r8());
        end
        repeat (3) begin
            e = base(3'd7); e.erro = 1'b1;
            step(e, rb(), rb(), r8());
        end
    endtask

    task automatic reset_mid_sw();
        obs_t e;
        fetch(I_SW, 0);
        e = base(3'd3); e.ulaFonte = 1'b1;
        step(e, rb(), rb(), r8());
        e = base(3'd4); e.ulaFonte = 1'b1; e.escreveMemo = 1'b1;
        step(e, 1'b0, rb(), r8());
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (escreveMemo === 1'b0 && estado === 3'd0 && instr_contador === 8'd0) passed++;
        else $display("FAIL async_reset escreveMemo=%b estado=%0d cnt=%0d want 0/0/0",
                      escreveMemo, estado, instr_contador);
        cnt = '0;
        @(posedge clk);
        #1;
        exp_q.push_back(base(3'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(base(3'd0));
    endtask

    initial begin
        do_reset();
        run_instr(I_ADD, 0, 0, 1'b0);
        run_instr(I_LW, 0, 3, 1'b0);
        run_instr(I_BEQ, 0, 0, 1'b1);
        run_instr(I_BEQ, 0, 0, 1'b0);
        run_instr(I_J, 1, 0, 1'b0);
        run_instr(I_SW, 2, 14, 1'b0);
        run_instr(I_ADDI, 14, 0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            logic [2:0] op;
            int bw, mw;
            op = 3'($urandom_range(0, 6));
            bw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 3);
            run_instr(op, bw, mw, rb());
        end
        reset_mid_sw();
        run_instr(I_SUB, 0, 0, 1'b0);
        do_reset();
        run_timeout();
        do_reset();
        run_instr(I_ADD, 0, 0, 1'b0);
        run_instr(I_HALT, 0, 0, 1'b0);
        do_reset();
        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 0 && guard < 10) begin
                @(posedge clk);
                guard++;
            end
            @(posedge clk);
            if (exp_q.size() > 0) begin
                checks++;
                $display("FAIL drain pending=%0d want 0", exp_q.size());
            end
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
